ps2_rx_ctrl: RTL and testbench

PS/2 receive controller that sequences the 11-bit frame shift register on the keyboard path. It conditions the raw `ps2_clk` line, detects falling edges to generate `shift_en`, and counts frame bits. It validates the start, parity and stop bits and presents each scancode byte to the consumer through a valid/ack handshake. It sits between the PS/2 pins and the scancode decoder.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 58 +++++
 rtl/shift_reg.sv | 31 +++
 rtl/ps2_rx_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive path.
//   ps2_state_e    - receive FSM state (IDLE, RECV, CHECK)
//   PS2_FRAME_BITS - bits per PS/2 frame
//   START/DATA_LSB/PARITY/STOP - bit positions within the shifted frame
//   odd_parity()   - parity bit that makes data plus parity hold an odd number of ones
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam int unsigned START    = 0;
    localparam int unsigned DATA_LSB = 1;
    localparam int unsigned PARITY   = 9;
    localparam int unsigned STOP     = 10;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: input conditioning for the PS/2 pins.
//   sys_clk   - clock
//   reset     - synchronous active-high reset (all state to 0)
//   ps2_clk   - raw PS/2 clock pin (asynchronous)
//   ps2_data  - raw PS/2 data pin (asynchronous)
//   clk_filt  - synchronized, glitch-filtered PS/2 clock
//   data_sync - synchronized PS/2 data
// The filtered clock only follows the synchronized clock after FILTER_LEN
// consecutive samples disagree with it, so the output lags the pin by
// 2 + FILTER_LEN cycles.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_filt_q, clk_filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        clk_filt_d = clk_filt_q;
        cnt_d      = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_filt_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_filt_q  <= clk_filt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign clk_filt  = clk_filt_q;
    assign data_sync = data_sync_q[1];

endmodule

// File: rtl/shift_reg.sv
// shift_reg: right-shifting serial-in parallel-out register.
//   sys_clk - clock
//   reset   - synchronous active-high reset, clears the register
//   clr     - synchronous clear
//   en      - shift enable; din enters the MSB, contents move toward bit 0
//   din     - serial input
//   q       - parallel contents
module shift_reg #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge sys_clk) begin
        if (reset || clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= {din, q_q[WIDTH-1:1]};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 keyboard receive controller.
//   sys_clk    - system clock, rising edge
//   reset      - synchronous active-high reset
//   ps2_clk    - raw PS/2 clock pin
//   ps2_data   - raw PS/2 data pin
//   rd_ack     - consumer accepts data while data_valid is high
//   data       - last received scancode byte
//   data_valid - data holds an unread byte
//   frame_err  - one-cycle pulse on bad start/parity/stop bit or timeout
//   overrun    - sticky: a frame completed while data_valid was high
//   busy       - frame in progress
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose parity bit
// is not the odd parity of the data byte; otherwise the parity bit is ignored.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic                      clk_filt, data_sync;
    logic                      clk_filt_prev_q;
    logic                      shift_en;
    logic                      shift_clr;
    logic [PS2_FRAME_BITS-1:0] frame_q;
    logic                      parity_ok, frame_ok;

    ps2_state_e state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic          data_valid_q, data_valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_filt  (clk_filt),
        .data_sync (data_sync)
    );

    assign shift_en = clk_filt_prev_q & ~clk_filt;

    shift_reg #(
        .WIDTH (PS2_FRAME_BITS)
    ) u_frame_shifter (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clr     (shift_clr),
        .en      (shift_en),
        .din     (data_sync),
        .q       (frame_q)
    );

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = (frame_q[PARITY] == odd_parity(frame_q[DATA_LSB +: 8]));
`else
    logic unused_parity_bit;
    assign unused_parity_bit = frame_q[PARITY];
    assign parity_ok         = 1'b1;
`endif

    assign frame_ok = ~frame_q[START] & frame_q[STOP] & parity_ok;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;
        shift_clr    = 1'b0;

        if (data_valid_q && rd_ack) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (shift_en) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                    tmo_d     = '0;
                end
            end
            RECV: begin
                if (shift_en) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_d     = '0;
                    if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_d = 1'b1;
                    shift_clr   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok) begin
                    // A load in the same cycle as rd_ack wins over the clear.
                    data_d       = frame_q[DATA_LSB +: 8];
                    data_valid_d = 1'b1;
                    if (data_valid_q && !rd_ack) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            clk_filt_prev_q <= 1'b0;
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            tmo_q           <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            overrun_q       <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            clk_filt_prev_q <= clk_filt;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            tmo_q           <= tmo_d;
            data_q          <= data_d;
            data_valid_q    <= data_valid_d;
            overrun_q       <= overrun_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl: scoreboard bench for ps2_rx_ctrl. Stimulus tasks push the
// expected outcome of each frame; a monitor pops on every byte load or
// frame_err pulse.
module tb_ps2_rx_ctrl;

    localparam int unsigned FILT = 4;
    localparam int unsigned TMO  = 300;
    localparam int unsigned HALF = 10;

    logic       sys_clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         ovr;
    } exp_t;

    exp_t exp_q[$];
    bit   model_unread = 1'b0;

    ps2_rx_ctrl #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_ack     (rd_ack),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Frame as transmitted: bit 0 first.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par,
                                               input bit st, input bit sp);
        return {sp, par, d, st};
    endfunction

    function automatic bit frame_good(input logic [10:0] f);
        bit ok;
        int ones;
        ok = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(f[i]);
        if (ones % 2 == 0) ok = 1'b0;
`else
        ones = 0;
`endif
        return ok;
    endfunction

    task automatic predict(input logic [10:0] f);
        exp_t e;
        if (frame_good(f)) begin
            e.is_err = 1'b0;
            e.data   = f[8:1];
            e.ovr    = model_unread;
            model_unread = 1'b1;
        end else begin
            e.is_err = 1'b1;
            e.data   = 8'h00;
            e.ovr    = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] f);
        predict(f);
        send_bits(f, 11);
        cyc(HALF);
    endtask

    task automatic do_ack();
        int w;
        w = 0;
        while (!data_valid && w < 100) begin
            cyc(1);
            w++;
        end
        check("ack_wait_valid", 32'(data_valid), 32'd1);
        rd_ack = 1'b1;
        cyc(1);
        rd_ack = 1'b0;
        check("valid_after_ack", 32'(data_valid), 32'd0);
        check("overrun_after_ack", 32'(overrun), 32'd0);
        model_unread = 1'b0;
    endtask

    // Monitor: every byte load and every frame_err cycle consumes one expectation.
    logic       dv_prev = 1'b0;
    logic [7:0] d_prev  = 8'h00;
    exp_t       mon_e;

    always @(negedge sys_clk) begin
        if (reset) begin
            dv_prev = 1'b0;
            d_prev  = 8'h00;
        end else begin
            if (frame_err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame_err: got frame_err=1, expected no event");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_is_err", 32'd1, 32'(mon_e.is_err));
                end
            end
            if (data_valid && (!dv_prev || data != d_prev)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_load: got data=0x%0h, expected no event", data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_is_load", 32'd0, 32'(mon_e.is_err));
                    if (!mon_e.is_err) begin
                        check("load_data", 32'(data), 32'(mon_e.data));
                        check("load_overrun", 32'(overrun), 32'(mon_e.ovr));
                    end
                end
            end
            dv_prev = data_valid;
            d_prev  = data;
        end
    end

    initial begin
        logic [10:0] f;
        logic [7:0]  d;
        int          kind;
        bit          par;
        bit          seen;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_ack   = 1'b0;
        cyc(4);
        @(negedge sys_clk);
        check("reset_data", 32'(data), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(20);

        // Good frame 0x1C.
        send_frame(make_frame(8'h1C, 1'b0, 1'b0, 1'b1));
        check("good_data", 32'(data), 32'h1C);
        check("good_busy_idle", 32'(busy), 32'd0);
        do_ack();

        // 0x1C with wrong parity.
        send_frame(make_frame(8'h1C, 1'b1, 1'b0, 1'b1));
        cyc(5);
`ifdef PS2_PARITY_CHECK_EN
        check("bad_parity_valid", 32'(data_valid), 32'd0);
`else
        check("bad_parity_data", 32'(data), 32'h1C);
`endif
        if (model_unread) do_ack();

        // Timeout after 5 bits, then a full 0x5A frame.
        f = make_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        exp_q.push_back('{is_err: 1'b1, data: 8'h00, ovr: 1'b0});
        send_bits(f, 5);
        cyc(TMO + 4 * HALF);
        check("timeout_busy", 32'(busy), 32'd0);
        send_frame(f);
        check("after_timeout_data", 32'(data), 32'h5A);
        do_ack();

        // Overrun: two frames without acknowledgement.
        send_frame(make_frame(8'h1C, 1'b0, 1'b0, 1'b1));
        send_frame(make_frame(8'hF0, 1'b1, 1'b0, 1'b1));
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_data", 32'(data), 32'hF0);
        do_ack();

        // Glitch rejection: 1- and 3-cycle low pulses.
        for (int g = 0; g < 2; g++) begin
            ps2_clk = 1'b0;
            cyc(g == 0 ? 1 : 3);
            ps2_clk = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                cyc(1);
                if (busy) seen = 1'b1;
            end
            check(g == 0 ? "glitch1_busy" : "glitch3_busy", 32'(seen), 32'd0);
        end

        // Reset in the middle of a frame.
        send_bits(make_frame(8'h1C, 1'b0, 1'b0, 1'b1), 6);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (busy || frame_err) seen = 1'b1;
        end
        check("reset_midframe_quiet", 32'(seen), 32'd0);
        cyc(20);
        send_frame(make_frame(8'h1C, 1'b0, 1'b0, 1'b1));
        check("after_reset_data", 32'(data), 32'h1C);
        do_ack();

        // Randomized frames, some with corrupted framing bits.
        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            par  = ~^d;
            if (kind == 7) par = ~par;
            f = make_frame(d, par, kind == 8, kind != 9);
            send_frame(f);
            if (model_unread) do_ack();
        end

        cyc(50);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
